// File: rtl/pim_vec_loader.sv
// pim_vec_loader: collects 8-bit elements from a valid/ready stream into a
// zero-padded packed vector. The vector is presented to the PIM macro with a
// bank address, held until the consumer takes it, then cleared for refill.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | one-cycle settle after reset; nothing accepted, nothing presented
// FILL  | in_ready=1; each accepted beat lands in slot fill_count
// HOLD  | vector complete; vec_valid/compute_flag=1 until vec_ready
module pim_vec_loader #(
  parameter int VECTWIDTH  = 100,
  parameter int DATA_WIDTH = 8,
  parameter int SLOT_WIDTH = 16,
  parameter int VARRAYSIZE = VECTWIDTH * SLOT_WIDTH,
  parameter int NUM_BANKS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [VARRAYSIZE-1:0] data_x,
  output logic                  vec_valid,
  input  logic                  vec_ready,
  output logic                  compute_flag,
  output logic [4:0]            pim_addr,
  output logic [6:0]            fill_count,
  output logic                  short_vec
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [6:0] LAST_IDX  = 7'(VECTWIDTH - 1);
  localparam logic [4:0] LAST_BANK = 5'(NUM_BANKS - 1);

  state_t                  state_q, state_d;
  logic [VARRAYSIZE-1:0]   data_x_q, data_x_d;
  logic [6:0]              fill_count_q, fill_count_d;
  logic [4:0]              pim_addr_q, pim_addr_d;
  logic                    short_vec_q, short_vec_d;

  // Next-state, slot write, close detection and bank advance.
  always_comb begin
    state_d      = state_q;
    data_x_d     = data_x_q;
    fill_count_d = fill_count_q;
    pim_addr_d   = pim_addr_q;
    short_vec_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FILL;
      end

      ST_FILL: begin
        if (in_valid) begin
          for (int k = 0; k < VECTWIDTH; k++) begin
            if (fill_count_q == 7'(k)) begin
              data_x_d[k*SLOT_WIDTH +: SLOT_WIDTH] =
                {{(SLOT_WIDTH - DATA_WIDTH){1'b0}}, in_data};
            end
          end
          fill_count_d = fill_count_q + 7'd1;
          // The last slot closes the vector even without in_last; only an
          // in_last that arrives earlier counts as a short vector.
          if (in_last || (fill_count_q == LAST_IDX)) begin
            state_d     = ST_HOLD;
            short_vec_d = in_last && (fill_count_q < LAST_IDX);
          end
        end
      end

      ST_HOLD: begin
        if (vec_ready) begin
          state_d      = ST_FILL;
          data_x_d     = '0;
          fill_count_d = 7'd0;
          pim_addr_d   = (pim_addr_q >= LAST_BANK) ? 5'd0 : pim_addr_q + 5'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      data_x_q     <= '0;
      fill_count_q <= 7'd0;
      pim_addr_q   <= 5'd0;
      short_vec_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_x_q     <= data_x_d;
      fill_count_q <= fill_count_d;
      pim_addr_q   <= pim_addr_d;
      short_vec_q  <= short_vec_d;
    end
  end

  assign in_ready     = (state_q == ST_FILL);
  assign vec_valid    = (state_q == ST_HOLD);
  assign compute_flag = (state_q == ST_HOLD);
  assign data_x       = data_x_q;
  assign fill_count   = fill_count_q;
  assign pim_addr     = pim_addr_q;
  assign short_vec    = short_vec_q;

endmodule

// File: tb/tb_pim_vec_loader.sv
// Bench for pim_vec_loader: directed and randomized vectors against an
// element-list model of the loader, with literal pins on key results.
module tb_pim_vec_loader;

  localparam int NB = 3;
  localparam int VW = 100;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [1599:0] data_x;
  logic          vec_valid;
  logic          vec_ready;
  logic          compute_flag;
  logic [4:0]    pim_addr;
  logic [6:0]    fill_count;
  logic          short_vec;

  always #5 clk = ~clk;

  pim_vec_loader #(.NUM_BANKS(NB)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .data_x(data_x),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .compute_flag(compute_flag),
    .pim_addr(pim_addr), .fill_count(fill_count), .short_vec(short_vec)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_vec(input string name, input logic [1599:0] act, input logic [1599:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      for (int k = 0; k < VW; k++) begin
        if (act[k*16 +: 16] !== exp[k*16 +: 16]) begin
          $display("FAIL %s slot=%0d actual=%04h required=%04h @%0t",
                   name, k, act[k*16 +: 16], exp[k*16 +: 16], $time);
          break;
        end
      end
    end
  endtask

  // Model: the list of elements received for the current vector, whether it
  // is being presented, and the bank counter.
  logic       m_idle, m_hold, m_short;
  int         m_count, m_bank;
  logic [7:0] m_elems [VW];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_idle <= 1'b1; m_hold <= 1'b0; m_short <= 1'b0;
      m_count <= 0; m_bank <= 0;
      for (int i = 0; i < VW; i++) m_elems[i] <= 8'h00;
    end else if (m_idle) begin
      m_idle <= 1'b0; m_short <= 1'b0;
    end else if (!m_hold) begin
      m_short <= 1'b0;
      if (in_valid) begin
        m_elems[m_count] <= in_data;
        m_count <= m_count + 1;
        if (in_last || (m_count + 1 == VW)) begin
          m_hold  <= 1'b1;
          m_short <= (m_count + 1 < VW);
        end
      end
    end else begin
      m_short <= 1'b0;
      if (vec_ready) begin
        m_hold <= 1'b0; m_count <= 0;
        m_bank <= (m_bank + 1) % NB;
        for (int i = 0; i < VW; i++) m_elems[i] <= 8'h00;
      end
    end
  end

  function automatic logic [1599:0] model_vec();
    logic [1599:0] v;
    for (int k = 0; k < VW; k++) v[k*16 +: 16] = {8'h00, m_elems[k]};
    return v;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in_ready",     in_ready,     !m_idle && !m_hold);
      chk("vec_valid",    vec_valid,    m_hold);
      chk("compute_flag", compute_flag, m_hold);
      chk("short_vec",    short_vec,    m_short);
      chk("fill_count",   fill_count,   m_count);
      chk("pim_addr",     pim_addr,     m_bank);
      chk_vec("data_x",   data_x,       model_vec());
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic last, input int gap_pct);
    int budget;
    while ($urandom_range(99) < gap_pct) begin
      in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1; in_data = d; in_last = last;
    budget = 0;
    while (!in_ready && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 200) chk("accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic release_vec(input int hold);
    repeat (hold) @(negedge clk);
    vec_ready = 1'b1;
    @(negedge clk);
    vec_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  in_ready,     0);
    chk({tag, "_vec_valid"}, vec_valid,    0);
    chk({tag, "_compute"},   compute_flag, 0);
    chk({tag, "_short"},     short_vec,    0);
    chk({tag, "_fill"},      fill_count,   0);
    chk({tag, "_addr"},      pim_addr,     0);
    chk_vec({tag, "_data"},  data_x,       '0);
  endtask

  logic [1599:0] exp_v, ref_v, hold_v;
  logic [7:0]    hi_or;
  logic [4:0]    addr_log [5];
  logic [7:0]    rnd [VW];
  int            len;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; vec_ready = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst0");
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_idle", in_ready, 1);

    // Vector 1: full, back-to-back, data k+1.
    for (int k = 0; k < VW; k++) send_beat(8'(k + 1), k == VW - 1, 0);
    chk("v1_vec_valid", vec_valid, 1);
    chk("v1_lsb", data_x[7:0], 8'h01);
    chk("v1_top", data_x[1591:1584], 8'h64);
    hi_or = 8'h00;
    for (int k = 0; k < VW; k++) hi_or = hi_or | data_x[k*16+8 +: 8];
    chk("v1_hi_bytes", hi_or, 0);
    chk("v1_fill", fill_count, 100);
    chk("v1_short", short_vec, 0);
    chk("model_pin_count", m_count, 100);
    chk("model_pin_elem99", m_elems[99], 8'h64);
    for (int k = 0; k < VW; k++) exp_v[k*16 +: 16] = 16'(k + 1);
    chk_vec("v1_full", data_x, exp_v);
    ref_v = data_x;
    addr_log[0] = pim_addr;
    release_vec(3);

    // Vector 2: early close after 10 x 0xFF, then a 20-cycle stall.
    for (int k = 0; k < 10; k++) send_beat(8'hFF, k == 9, 0);
    chk("v2_short_pulse", short_vec, 1);
    chk("v2_fill", fill_count, 10);
    exp_v = '0;
    for (int k = 0; k < 10; k++) exp_v[k*16 +: 16] = 16'h00FF;
    chk_vec("v2_padded", data_x, exp_v);
    hold_v = data_x;
    addr_log[1] = pim_addr;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_data = 8'($urandom); in_last = 1'($urandom);
      @(negedge clk);
      chk("v2_stall_ready", in_ready, 0);
      chk_vec("v2_stall_data", data_x, hold_v);
    end
    chk("v2_short_once", short_vec, 0);
    vec_ready = 1'b1;
    @(negedge clk);
    vec_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("v2_rel_valid", vec_valid, 0);
    chk_vec("v2_rel_data", data_x, '0);
    chk("v2_rel_ready", in_ready, 1);

    // Vector 3: same data as vector 1, 50% gaps.
    for (int k = 0; k < VW; k++) send_beat(8'(k + 1), k == VW - 1, 50);
    chk_vec("v3_gapped", data_x, ref_v);
    addr_log[2] = pim_addr;
    release_vec($urandom_range(0, 4));

    // Vector 4: random length and data, light gaps.
    len = $urandom_range(1, VW);
    for (int k = 0; k < len; k++) rnd[k] = 8'($urandom);
    for (int k = 0; k < len; k++)
      send_beat(rnd[k], (k == len - 1) ? ((len < VW) ? 1'b1 : 1'($urandom)) : 1'b0, 30);
    chk("v4_valid", vec_valid, 1);
    chk("v4_short", short_vec, len < VW);
    chk("v4_fill", fill_count, len);
    addr_log[3] = pim_addr;
    release_vec($urandom_range(0, 4));

    // Vector 5: 100 random beats, in_last never set.
    for (int k = 0; k < VW; k++) send_beat(8'($urandom), 1'b0, 20);
    chk("v5_valid", vec_valid, 1);
    chk("v5_short", short_vec, 0);
    addr_log[4] = pim_addr;
    release_vec(1);

    chk("addr_seq0", addr_log[0], 0);
    chk("addr_seq1", addr_log[1], 1);
    chk("addr_seq2", addr_log[2], 2);
    chk("addr_seq3", addr_log[3], 0);
    chk("addr_seq4", addr_log[4], 1);

    // Reset after 40 accepted beats.
    for (int k = 0; k < 40; k++) send_beat(8'($urandom), 1'b0, 0);
    #2 reset = 1'b1;
    #1 chk_reset_outputs("rst1");
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < VW; k++) rnd[k] = 8'($urandom);
    for (int k = 0; k < VW; k++) send_beat(rnd[k], k == VW - 1, 25);
    for (int k = 0; k < VW; k++) exp_v[k*16 +: 16] = {8'h00, rnd[k]};
    chk_vec("post_reset_vec", data_x, exp_v);
    chk("post_reset_addr", pim_addr, 0);
    release_vec(2);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
